// File: rtl/hybrid_cache_linefill.sv
// rtl/hybrid_cache_linefill.sv - cache line fill engine: one external word read per line-memory write
// Optional critical-word-first ordering: define HYBRID_CACHE_CRITICAL_WORD_FIRST_EN.
module hybrid_cache_linefill #(
    parameter int ADDRBITS = 32,
    parameter int DATABITS = 32,
    parameter int LSBBITS  = 7
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                fill_req,
    input  logic [ADDRBITS-1:0] fill_addr,
    input  logic                fill_abort,
    output logic                fill_busy,
    output logic                fill_crit,
    output logic                fill_done,
    output logic                mem_rdreq,
    output logic [ADDRBITS-1:0] mem_addr,
    input  logic                mem_rdvalid,
    input  logic [DATABITS-1:0] mem_rddata,
    output logic [LSBBITS-1:0]  line_mem_wraddr,
    output logic                line_mem_we,
    output logic [DATABITS-1:0] line_mem_in,
    output logic [1:0]          line_mem_in_wordlen
);
    localparam int IDXBITS = LSBBITS - 2;
    localparam int CNTBITS = LSBBITS - 1;
    localparam logic [CNTBITS-1:0] NWORDS  = {1'b1, {IDXBITS{1'b0}}};
    localparam logic [CNTBITS-1:0] CNT_ONE = {{(CNTBITS-1){1'b0}}, 1'b1};
    localparam logic [IDXBITS-1:0] IDX_ONE = {{(IDXBITS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

    state_t                       state_q, state_d;
    logic [ADDRBITS-LSBBITS-1:0]  base_q;
    logic [IDXBITS-1:0]           idx_q;
    logic [CNTBITS-1:0]           cnt_q;
    logic [CNTBITS-1:0]           cnt_inc;
    logic [DATABITS-1:0]          data_q;
    logic [IDXBITS-1:0]           start_idx;
    logic                         unused_addr_bits;

`ifdef HYBRID_CACHE_CRITICAL_WORD_FIRST_EN
    assign start_idx = fill_addr[LSBBITS-1:2];
`else
    assign start_idx = '0;
`endif
    assign unused_addr_bits = ^fill_addr[LSBBITS-1:0];

    assign cnt_inc = cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (fill_req) state_d = READ;
            READ:    if (mem_rdvalid) state_d = WRITE;
            WRITE:   state_d = (cnt_inc == NWORDS) ? DONE : READ;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Abort wins over every other event, including a coincident rdvalid.
        if (fill_abort && state_q != IDLE) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            base_q  <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (fill_req) begin
                        base_q <= fill_addr[ADDRBITS-1:LSBBITS];
                        idx_q  <= start_idx;
                        cnt_q  <= '0;
                    end
                end
                READ: begin
                    if (mem_rdvalid && !fill_abort) data_q <= mem_rddata;
                end
                WRITE: begin
                    if (!fill_abort) begin
                        idx_q <= idx_q + IDX_ONE;
                        cnt_q <= cnt_inc;
                    end
                end
                default: ;
            endcase
        end
    end

    assign fill_busy           = (state_q != IDLE);
    assign fill_crit           = (state_q == WRITE) && (cnt_q == '0);
    assign fill_done           = (state_q == DONE);
    assign mem_rdreq           = (state_q == READ);
    assign mem_addr            = {base_q, idx_q, 2'b00};
    assign line_mem_we         = (state_q == WRITE);
    assign line_mem_wraddr     = {idx_q, 2'b00};
    assign line_mem_in         = data_q;
    assign line_mem_in_wordlen = 2'b10;

endmodule

// File: tb/tb_hybrid_cache_linefill.sv
// tb/tb_hybrid_cache_linefill.sv - randomized line-fill bench with a reference memory and fill-order model
module tb_hybrid_cache_linefill;
    localparam int NW = 32;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        fill_req = 1'b0;
    logic [31:0] fill_addr = '0;
    logic        fill_abort = 1'b0;
    logic        fill_busy, fill_crit, fill_done, mem_rdreq, line_mem_we;
    logic [31:0] mem_addr, line_mem_in;
    logic        mem_rdvalid = 1'b0;
    logic [31:0] mem_rddata = '0;
    logic [6:0]  line_mem_wraddr;
    logic [1:0]  line_mem_in_wordlen;

    int n_checks = 0;
    int n_pass = 0;
    logic [31:0] seed;

    hybrid_cache_linefill dut (
        .clk(clk), .reset_n(reset_n),
        .fill_req(fill_req), .fill_addr(fill_addr), .fill_abort(fill_abort),
        .fill_busy(fill_busy), .fill_crit(fill_crit), .fill_done(fill_done),
        .mem_rdreq(mem_rdreq), .mem_addr(mem_addr),
        .mem_rdvalid(mem_rdvalid), .mem_rddata(mem_rddata),
        .line_mem_wraddr(line_mem_wraddr), .line_mem_we(line_mem_we),
        .line_mem_in(line_mem_in), .line_mem_in_wordlen(line_mem_in_wordlen)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ seed;
    endfunction

    task automatic check_reset_outputs();
        check("rst_busy", 32'(fill_busy), 0);
        check("rst_crit", 32'(fill_crit), 0);
        check("rst_done", 32'(fill_done), 0);
        check("rst_rdreq", 32'(mem_rdreq), 0);
        check("rst_we", 32'(line_mem_we), 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_wraddr", 32'(line_mem_wraddr), 0);
        check("rst_line_in", line_mem_in, 0);
        check("rst_wordlen", 32'(line_mem_in_wordlen), 2);
    endtask

    // lat: cycles mem_rdreq is high up to and including the rdvalid cycle.
    // abort_rd: abort during that READ (1-based), 0 = none. rst_wr: reset at that write index, -1 = none.
    task automatic run_fill(input logic [31:0] addr, input int lat, input int abort_rd,
                            input bit spur, input bit hold_req, input int rst_wr);
        int s, wr_cnt, rd_k, age, start_cyc, exp_lat, diff;
        logic [31:0] base, req_addr, exp_off;
        bit started, finished, pending, aborting;
`ifdef HYBRID_CACHE_CRITICAL_WORD_FIRST_EN
        s = int'(addr[6:2]);
`else
        s = 0;
`endif
        base = {addr[31:7], 7'b0};
        wr_cnt = 0; rd_k = 0; age = 0; start_cyc = 0; req_addr = '0;
        started = 0; finished = 0; pending = 0; aborting = 0;
        exp_lat = NW * (lat + 1);
        @(negedge clk);
        fill_req = 1'b1; fill_addr = addr;
        for (int cyc = 0; cyc < 5000 && !finished; cyc++) begin
            @(negedge clk);
            mem_rdvalid = 1'b0;
            fill_abort = 1'b0;
            if (aborting) begin
                check("abort_idle", 32'(fill_busy), 0);
                check("abort_we", 32'(line_mem_we), 0);
                check("abort_writes", 32'(wr_cnt), 32'(abort_rd - 1));
                finished = 1;
                break;
            end
            if (!started) begin
                check("busy_rise", 32'(fill_busy), 1);
                started = 1; start_cyc = cyc;
                if (!hold_req) fill_req = 1'b0;
            end
            if (line_mem_wraddr[1:0] != 2'b00 || line_mem_in_wordlen != 2'b10)
                check("wordlen_align", {line_mem_wraddr[1:0], line_mem_in_wordlen}, 32'b0010);
            check("crit", 32'(fill_crit), 32'(line_mem_we && wr_cnt == 0));
            if (line_mem_we) begin
                exp_off = 32'(((s + wr_cnt) % NW) * 4);
                check("we_after_rdvalid", 32'(pending), 1);
                pending = 0;
                check("wr_addr", 32'(line_mem_wraddr), exp_off);
                check("wr_data", line_mem_in, data_of(base | exp_off));
                if (wr_cnt == rst_wr) begin
                    reset_n = 1'b0; fill_req = 1'b0;
                    #1;
                    check_reset_outputs();
                    @(negedge clk);
                    reset_n = 1'b1;
                    for (int k = 0; k < 4; k++) begin
                        @(negedge clk);
                        check("post_reset_idle", 32'(fill_busy), 0);
                    end
                    finished = 1;
                    break;
                end
                wr_cnt++;
            end
            if (fill_done) begin
                diff = cyc - start_cyc;
                check("done_writes", 32'(wr_cnt), NW);
                check("done_latency", 32'(diff >= exp_lat - 1 && diff <= exp_lat + 1), 1);
                fill_req = 1'b0;
                finished = 1;
            end
            if (mem_rdreq) begin
                if (age == 0) begin
                    check("rd_addr", mem_addr, base | 32'(((s + rd_k) % NW) * 4));
                    req_addr = mem_addr;
                end else begin
                    check("rd_stable", mem_addr, req_addr);
                end
                if (abort_rd == rd_k + 1 && age + 1 == lat) begin
                    fill_abort = 1'b1;
                    aborting = 1;
                end
                age++;
                if (age == lat) begin
                    mem_rdvalid = 1'b1;
                    mem_rddata = data_of(mem_addr);
                    pending = 1; age = 0; rd_k++;
                end
            end else if (spur) begin
                mem_rdvalid = 1'($urandom_range(0, 1));
                mem_rddata = $urandom;
            end
        end
        if (!finished) check("timeout", 0, 1);
        fill_req = 1'b0; fill_abort = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            mem_rdvalid = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            check("idle_we", 32'(line_mem_we), 0);
            check("idle_done", 32'(fill_done), 0);
            check("idle_busy", 32'(fill_busy), 0);
        end
        mem_rdvalid = 1'b0;
    endtask

    initial begin
        seed = $urandom;
        #1;
        check_reset_outputs();
        repeat (3) @(negedge clk);
        check_reset_outputs();
        reset_n = 1'b1;
        run_fill(32'h0000_1234, 2, 0, 0, 0, -1);
        run_fill($urandom, 5, 0, 0, 0, -1);
        run_fill($urandom, 2, 10, 0, 0, -1);
        run_fill($urandom, 1, 0, 0, 0, -1);
        run_fill($urandom, 3, 7, 0, 0, -1);
        run_fill($urandom, 2, 0, 0, 0, 3);
        run_fill($urandom, 3, 0, 1, 1, -1);
        for (int i = 0; i < 3; i++)
            run_fill($urandom, int'($urandom_range(1, 4)), 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/hybrid_cache_linefill.md
HYBRID_CACHE_LINEFILL -- requirements
Module: hybrid_cache_linefill

Interface
REQ-001 Parameter ADDRBITS, default 32, SHALL set the byte address width.
REQ-002 Parameter DATABITS, default 32, SHALL set the data word width; only 32 is supported.
REQ-003 Parameter LSBBITS, default 7, SHALL set the line-offset width; a line holds 2^(LSBBITS-2) words, which is 32 words by default.
REQ-004 Port clk, input, 1 bit, SHALL be the single clock; all state changes on its rising edge.
REQ-005 Port reset_n, input, 1 bit, SHALL be the asynchronous, active-low reset.
REQ-006 Port fill_req, input, 1 bit, SHALL request a line fill; it is sampled only in IDLE.
REQ-007 Port fill_addr, input, ADDRBITS bits, SHALL carry the miss byte address; it is sampled together with fill_req.
REQ-008 Port fill_abort, input, 1 bit, SHALL cancel the fill in progress.
REQ-009 Port fill_busy, output, 1 bit, SHALL be high whenever the state is not IDLE.
REQ-010 Port fill_crit, output, 1 bit, SHALL be a one-cycle pulse in the cycle the first word is written.
REQ-011 Port fill_done, output, 1 bit, SHALL be a one-cycle pulse when the line is complete.
REQ-012 Port mem_rdreq, output, 1 bit, SHALL be the external read request.
REQ-013 Port mem_addr, output, ADDRBITS bits, SHALL be the external word address; its low 2 bits are always 0.
REQ-014 Port mem_rdvalid, input, 1 bit, SHALL be a one-cycle pulse that qualifies mem_rddata.
REQ-015 Port mem_rddata, input, DATABITS bits, SHALL carry the external read data.
REQ-016 Port line_mem_wraddr, output, LSBBITS bits, SHALL be the line-memory write byte address.
REQ-017 Port line_mem_we, output, 1 bit, SHALL be the line-memory write enable.
REQ-018 Port line_mem_in, output, DATABITS bits, SHALL be the line-memory write data.
REQ-019 Port line_mem_in_wordlen, output, 2 bits, SHALL be the write length and SHALL be constant 2'b10 (word).

Function
REQ-020 The state machine SHALL have four states: IDLE, READ, WRITE and DONE.
REQ-021 In IDLE with fill_req=1, the block SHALL latch the line base fill_addr[ADDRBITS-1:LSBBITS] and the start word index, clear the word counter and enter READ.
REQ-022 In READ, mem_rdreq SHALL be 1 and mem_addr SHALL be {base, word_idx, 2'b00}; both SHALL stay stable until mem_rdvalid.
REQ-023 In READ with mem_rdvalid=1, the block SHALL register mem_rddata, drop mem_rdreq in the next cycle and enter WRITE.
REQ-024 In WRITE, for exactly one cycle, the block SHALL drive line_mem_we=1, line_mem_wraddr={word_idx, 2'b00} and line_mem_in equal to the registered data.
REQ-025 In the WRITE cycle, the block SHALL increment word_idx modulo 2^(LSBBITS-2) and increment the counter.
REQ-026 From WRITE, the block SHALL return to READ unless the counter has reached 2^(LSBBITS-2), in which case it SHALL enter DONE.
REQ-027 The block SHALL write exactly 2^(LSBBITS-2) words per fill.
REQ-028 Latency SHALL be 1 cycle from mem_rdvalid to line_mem_we.
REQ-029 With zero-wait external memory, one word SHALL be written every 3 cycles.
REQ-030 The block SHALL pulse fill_crit in the WRITE cycle of the first word only.
REQ-031 DONE SHALL last one cycle, SHALL pulse fill_done and SHALL then return to IDLE.
REQ-032 fill_req while not IDLE SHALL be ignored; the requester holds it until fill_busy rises.
REQ-033 fill_abort in any non-IDLE state SHALL force IDLE in the next cycle, with no further line_mem_we and no fill_done.
REQ-034 If mem_rdvalid arrives in the same cycle as fill_abort, its data SHALL be discarded.
REQ-035 fill_abort SHALL take priority over every other event.
REQ-036 mem_rdvalid outside READ SHALL be ignored.
REQ-037 line_mem_we SHALL be 0 in every state except WRITE.

Reset
REQ-038 While reset_n=0, the state SHALL be IDLE and fill_busy, fill_crit, fill_done, mem_rdreq and line_mem_we SHALL be 0.
REQ-039 While reset_n=0, mem_addr, line_mem_wraddr, line_mem_in, word_idx and the counter SHALL be 0, and line_mem_in_wordlen SHALL be 2'b10.
REQ-040 Reset asserted mid-fill SHALL abandon the fill immediately, with no fill_done; line contents are then undefined.

Configuration
REQ-041 Macro HYBRID_CACHE_CRITICAL_WORD_FIRST_EN defined: the start word index SHALL be fill_addr[LSBBITS-1:2] and the order SHALL wrap from word 2^(LSBBITS-2)-1 to word 0.
REQ-042 Macro HYBRID_CACHE_CRITICAL_WORD_FIRST_EN undefined: the start word index SHALL be 0, giving sequential order 0..2^(LSBBITS-2)-1, and fill_crit SHALL pulse with the word-0 write.

Verification
REQ-043 Scenario: fill_addr=0x00001234 with the macro undefined and zero-wait memory -> mem_addr sequence 0x00001200, 0x00001204, ... 0x0000127C; 32 writes to wraddr 0x00..0x7C; fill_done 96 cycles after busy, +/-1.
REQ-044 Scenario: same request with the macro defined -> first mem_addr 0x00001234 and first wraddr 0x34; fill_crit with that write; after 0x7C the wraddr wraps to 0x00; last wraddr 0x30.
REQ-045 Scenario: memory with 5-cycle rdvalid delay -> mem_rdreq and mem_addr stable for 5 cycles per word; exactly one line_mem_we per rdvalid; wordlen always 2'b10.
REQ-046 Scenario: fill_abort during the 10th READ -> IDLE next cycle, 9 writes total, no fill_done; a new fill_req is then accepted normally.
REQ-047 Scenario: reset_n pulled low during WRITE of word 3 -> all outputs 0 asynchronously (wordlen 2'b10); after release, fill_req=0 keeps the block IDLE.
REQ-048 Scenario: spurious mem_rdvalid in IDLE and DONE, plus fill_req held high while busy -> no writes and no second fill until IDLE.
